// File: rtl/image_filter_seq.sv
// -----------------------------------------------------------------------------
// image_filter_seq
// Sequential binary-image filter. One row of the image is filtered per clock
// from a work buffer into a result buffer; multi-pass operation feeds the
// result back into the work buffer. The final image is presented on a
// registered output together with a one-cycle done pulse.
//
// Parameters
//   IMG_W    image width in pixels
//   IMG_H    image height in rows
//   REVERSE  1 = out_image bit order reversed, 0 = natural order
//
// Ports
//   clk        clock, rising edge active
//   rst_n      asynchronous active-low reset (aborts any operation)
//   start      request to process in_image (ignored while busy)
//   mode       0 copy, 1 gap-fill, 2 dilate, 3 erode
//   wrap_en    1 = neighbor index taken modulo N, 0 = zero border
//   iter       pass count, 0 is treated as 1
//   in_image   input image, pixel k = r*IMG_W + c at bit k
//   out_image  registered result image
//   busy       high from start acceptance until done
//   done       one-cycle pulse when out_image is updated
// -----------------------------------------------------------------------------
module image_filter_seq #(
   parameter int IMG_W   = 32,
   parameter int IMG_H   = 32,
   parameter int REVERSE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic                     wrap_en,
   input  logic [1:0]               iter,
   input  logic [IMG_W*IMG_H-1:0]   in_image,
   output logic [IMG_W*IMG_H-1:0]   out_image,
   output logic                     busy,
   output logic                     done
);

   localparam int N  = IMG_W * IMG_H;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PROC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;

   logic [N-1:0]    work_r;
   logic [N-1:0]    res_r;
   logic [N-1:0]    res_nx_s;
   logic [N-1:0]    out_image_r;
   logic [1:0]      mode_r;
   logic            wrap_r;
   logic [1:0]      iter_r;
   logic [RW-1:0]   row_r;
   logic [1:0]      pass_r;
   logic            busy_r;
   logic            done_r;

   logic            last_row_s;
   logic            last_pass_s;
   logic [1:0]      final_pass_s;
   logic            accept_s;
   logic            step_s;
   logic            repass_s;
   logic            finish_s;
   logic            busy_nx_s;
   logic            done_nx_s;

   // Filter one pixel at (r, c) of image w. Wrapped neighbors use linear
   // modulo-N indexing, so row ends wrap onto the adjacent row.
   function automatic logic calc_pixel(input logic [N-1:0] w, input int r,
                                       input int c, input logic [1:0] md,
                                       input logic wr);
      int   k;
      logic ctr, l, rt, u, d, ul;
      logic res;
      k   = r * IMG_W + c;
      ctr = w[KW'(k)];
      if (wr) begin
         l  = (k == 0)          ? w[KW'(N - 1)]         : w[KW'(k - 1)];
         rt = (k == N - 1)      ? w[KW'(0)]             : w[KW'(k + 1)];
         u  = (k < IMG_W)       ? w[KW'(k + N - IMG_W)] : w[KW'(k - IMG_W)];
         d  = (k >= N - IMG_W)  ? w[KW'(k + IMG_W - N)] : w[KW'(k + IMG_W)];
         ul = (k < IMG_W + 1)   ? w[KW'(k + N - IMG_W - 1)] : w[KW'(k - IMG_W - 1)];
      end else begin
         l  = (c > 0)             ? w[KW'(k - 1)]         : 1'b0;
         rt = (c < IMG_W - 1)     ? w[KW'(k + 1)]         : 1'b0;
         u  = (r > 0)             ? w[KW'(k - IMG_W)]     : 1'b0;
         d  = (r < IMG_H - 1)     ? w[KW'(k + IMG_W)]     : 1'b0;
         ul = (r > 0 && c > 0)    ? w[KW'(k - IMG_W - 1)] : 1'b0;
      end
      case (md)
         2'd0:    res = ctr;
         2'd1:    res = ctr | (l & u) | (u & ul) | (l & ul);
         2'd2:    res = ctr | l | rt | u | d;
         2'd3:    res = ctr & l & rt & u & d;
         default: res = ctr;
      endcase
      return res;
   endfunction

   // Mirror the bit order of an image.
   function automatic logic [N-1:0] reverse_img(input logic [N-1:0] img);
      logic [N-1:0] o;
      for (int i = 0; i < N; i++) begin
         o[i] = img[N-1-i];
      end
      return o;
   endfunction

   // Current row and pass position flags.
   always_comb begin
      last_row_s   = (row_r == RW'(IMG_H - 1));
      final_pass_s = (iter_r == 2'd0) ? 2'd0 : (iter_r - 2'd1);
      last_pass_s  = (pass_r == final_pass_s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = PROC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         PROC: begin
            if (last_row_s && last_pass_s) begin
               state_nx_s = FINISH;
            end else begin
               state_nx_s = PROC;
            end
         end
         FINISH:  state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Control decode and next values of the registered status outputs.
   always_comb begin
      accept_s  = 1'b0;
      step_s    = 1'b0;
      repass_s  = 1'b0;
      finish_s  = 1'b0;
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s  = start;
            busy_nx_s = start;
         end
         PROC: begin
            step_s    = 1'b1;
            repass_s  = last_row_s & ~last_pass_s;
            busy_nx_s = 1'b1;
         end
         FINISH: begin
            finish_s  = 1'b1;
            done_nx_s = 1'b1;
         end
         default: begin
            accept_s  = 1'b0;
         end
      endcase
   end

   // Result of the current row merged into the result buffer.
   always_comb begin
      res_nx_s = res_r;
      for (int c = 0; c < IMG_W; c++) begin
         res_nx_s[KW'(int'(row_r) * IMG_W + c)] =
            calc_pixel(work_r, int'(row_r), c, mode_r, wrap_r);
      end
   end

   // Datapath: operand latch, row/pass stepping, buffer feedback, output load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_r      <= {N{1'b0}};
         res_r       <= {N{1'b0}};
         out_image_r <= {N{1'b0}};
         mode_r      <= 2'd0;
         wrap_r      <= 1'b0;
         iter_r      <= 2'd0;
         row_r       <= {RW{1'b0}};
         pass_r      <= 2'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         if (accept_s) begin
            work_r <= in_image;
            mode_r <= mode;
            wrap_r <= wrap_en;
            iter_r <= iter;
            row_r  <= {RW{1'b0}};
            pass_r <= 2'd0;
         end else if (step_s) begin
            res_r <= res_nx_s;
            if (last_row_s) begin
               row_r <= {RW{1'b0}};
               if (repass_s) begin
                  // Next pass reads the just-completed result, last row included.
                  work_r <= res_nx_s;
                  pass_r <= pass_r + 2'd1;
               end else begin
                  pass_r <= pass_r;
               end
            end else begin
               row_r <= row_r + RW'(1);
            end
         end else begin
            row_r <= row_r;
         end
         if (finish_s) begin
            out_image_r <= (REVERSE != 0) ? reverse_img(res_r) : res_r;
         end else begin
            out_image_r <= out_image_r;
         end
         busy_r <= busy_nx_s;
         done_r <= done_nx_s;
      end
   end

   assign out_image = out_image_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_image_filter_seq.sv
// -----------------------------------------------------------------------------
// tb_image_filter_seq
// Two 4x4 instances (REVERSE=1 and REVERSE=0) share all inputs. Expected
// images and latencies are queued when an operation is started and popped
// when done is seen.
// -----------------------------------------------------------------------------
module tb_image_filter_seq;

   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    mode;
   logic          wrap_en;
   logic [1:0]    iter;
   logic [N-1:0]  in_image;
   logic [N-1:0]  out_rev;
   logic [N-1:0]  out_nat;
   logic          busy_rev, busy_nat;
   logic          done_rev, done_nat;

   int total;
   int bad;

   typedef struct {
      logic [N-1:0] img;
      int           lat;
   } exp_t;

   exp_t sb[$];

   image_filter_seq #(.IMG_W(W), .IMG_H(H), .REVERSE(1)) dut_rev (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .wrap_en(wrap_en),
      .iter(iter), .in_image(in_image), .out_image(out_rev), .busy(busy_rev),
      .done(done_rev)
   );

   image_filter_seq #(.IMG_W(W), .IMG_H(H), .REVERSE(0)) dut_nat (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .wrap_en(wrap_en),
      .iter(iter), .in_image(in_image), .out_image(out_nat), .busy(busy_nat),
      .done(done_nat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] rev16(input logic [N-1:0] v);
      logic [N-1:0] o;
      for (int i = 0; i < N; i++) o[i] = v[N-1-i];
      return o;
   endfunction

   // Neighbor at row offset dr, column offset dc from (r, c).
   function automatic logic nbr(input logic [N-1:0] img, input int r, input int c,
                                input int dr, input int dc, input logic wr);
      int rr, cc, idx;
      if (wr) begin
         idx = ((r * W + c + dr * W + dc) % N + N) % N;
         return img[idx];
      end
      rr = r + dr;
      cc = c + dc;
      if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 1'b0;
      return img[rr * W + cc];
   endfunction

   function automatic logic [N-1:0] model_pass(input logic [N-1:0] img,
                                               input logic [1:0] md, input logic wr);
      logic [N-1:0] o;
      logic x, l, rt, u, d, ul;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            x  = img[r * W + c];
            l  = nbr(img, r, c, 0, -1, wr);
            rt = nbr(img, r, c, 0, 1, wr);
            u  = nbr(img, r, c, -1, 0, wr);
            d  = nbr(img, r, c, 1, 0, wr);
            ul = nbr(img, r, c, -1, -1, wr);
            case (md)
               2'd0:    o[r * W + c] = x;
               2'd1:    o[r * W + c] = x | (l & u) | (u & ul) | (l & ul);
               2'd2:    o[r * W + c] = x | l | rt | u | d;
               default: o[r * W + c] = x & l & rt & u & d;
            endcase
         end
      end
      return o;
   endfunction

   // Start one operation, optionally poke start while busy, and check result.
   task automatic run_op(input logic [1:0] md, input logic wr, input logic [1:0] it,
                         input logic [N-1:0] img, input bit poke,
                         input logic [N-1:0] exp_nat, input string name);
      exp_t e;
      exp_t g;
      int   n;
      bit   got;
      int   p;
      logic [N-1:0] held;
      p     = (it == 2'd0) ? 1 : int'(it);
      e.img = exp_nat;
      e.lat = p * H + 1;
      @(negedge clk);
      mode = md; wrap_en = wr; iter = it; in_image = img; start = 1'b1;
      @(posedge clk);
      sb.push_back(e);
      n = 0;
      @(negedge clk);
      start = 1'b0;
      in_image = N'($urandom);
      mode = ~md; wrap_en = ~wr; iter = it + 2'd1;
      total++;
      if (busy_nat !== 1'b1 || busy_rev !== 1'b1) begin
         bad++;
         $display("FAIL %s busy: got %b/%b want 1", name, busy_rev, busy_nat);
      end
      got = 0;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (done_nat === 1'b1 || done_rev === 1'b1) got = 1;
         if (poke && n == 2) begin start = 1'b1; mode = 2'd3; end
         if (poke && n == 3) start = 1'b0;
      end
      start = 1'b0;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s timeout: no done within 100 cycles", name);
         void'(sb.pop_front());
         return;
      end
      g = sb.pop_front();
      total++;
      if (n !== g.lat) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", name, n, g.lat);
      end
      total++;
      if (out_nat !== g.img) begin
         bad++;
         $display("FAIL %s out_nat: got %h want %h", name, out_nat, g.img);
      end
      total++;
      if (out_rev !== rev16(g.img)) begin
         bad++;
         $display("FAIL %s out_rev: got %h want %h", name, out_rev, rev16(g.img));
      end
      total++;
      if (done_nat !== 1'b1 || done_rev !== 1'b1 || busy_nat !== 1'b0 || busy_rev !== 1'b0) begin
         bad++;
         $display("FAIL %s done/busy: got done %b/%b busy %b/%b want 1/1 0/0",
                  name, done_rev, done_nat, busy_rev, busy_nat);
      end
      held = out_nat;
      in_image = ~img;
      @(posedge clk);
      #1;
      total++;
      if (done_nat !== 1'b0 || done_rev !== 1'b0 || out_nat !== held) begin
         bad++;
         $display("FAIL %s hold: got done %b/%b out %h want 0/0 %h",
                  name, done_rev, done_nat, out_nat, held);
      end
   endtask

   task automatic test_reset();
      start = 1'b0; mode = 2'd0; wrap_en = 1'b0; iter = 2'd0; in_image = '0;
      rst_n = 1'b0;
      #23;
      total++;
      if (out_nat !== 16'h0000 || out_rev !== 16'h0000 || busy_nat !== 1'b0 ||
          done_nat !== 1'b0 || busy_rev !== 1'b0 || done_rev !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got out %h/%h busy %b done %b want 0", out_rev,
                  out_nat, busy_nat, done_nat);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_gapfill();
      run_op(2'd1, 1'b0, 2'd1, 16'h0012, 1'b0, 16'h0032, "gapfill");
   endtask

   task automatic test_dilate();
      run_op(2'd2, 1'b0, 2'd1, 16'h0020, 1'b0, 16'h0272, "dilate");
   endtask

   task automatic test_erode();
      run_op(2'd3, 1'b0, 2'd1, 16'hFFFF, 1'b0, 16'h0660, "erode_border");
      run_op(2'd3, 1'b1, 2'd1, 16'hFFFF, 1'b0, 16'hFFFF, "erode_wrap");
   endtask

   task automatic test_multipass();
      run_op(2'd2, 1'b0, 2'd3, 16'h0001, 1'b0, 16'h137F, "multipass3");
      run_op(2'd2, 1'b0, 2'd0, 16'h0001, 1'b0, 16'h0013, "iter0");
   endtask

   task automatic test_busy_start();
      run_op(2'd0, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0001, "copy_poke");
   endtask

   task automatic test_random();
      logic [1:0]   md, it;
      logic         wr;
      logic [N-1:0] img, e;
      int           p;
      for (int t = 0; t < 8; t++) begin
         md  = 2'($urandom_range(0, 3));
         it  = 2'($urandom_range(0, 3));
         wr  = 1'($urandom_range(0, 1));
         img = N'($urandom);
         p   = (it == 2'd0) ? 1 : int'(it);
         e   = img;
         for (int i = 0; i < p; i++) e = model_pass(e, md, wr);
         run_op(md, wr, it, img, 1'b0, e, $sformatf("rand%0d", t));
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      mode = 2'd2; wrap_en = 1'b0; iter = 2'd2; in_image = 16'h0421; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_nat !== 16'h0000 || out_rev !== 16'h0000 || busy_nat !== 1'b0 ||
          busy_rev !== 1'b0 || done_nat !== 1'b0 || done_rev !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got out %h/%h busy %b/%b done %b/%b want 0",
                  out_rev, out_nat, busy_rev, busy_nat, done_rev, done_nat);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (done_nat === 1'b1 || done_rev === 1'b1 || busy_nat === 1'b1) seen = 1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_mid_nodone: got activity after abort want none");
      end
      run_op(2'd2, 1'b1, 2'd1, 16'h8001, 1'b0, model_pass(16'h8001, 2'd2, 1'b1),
             "after_reset");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_gapfill();
      test_dilate();
      test_erode();
      test_multipass();
      test_busy_start();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
